cam_learn_ctrl: RTL and testbench

// Sequencer for the block-RAM CAM in the L2 switch MAC table. Arbitrates lookup
// and learn requests onto the CAM compare/write ports, keeps a per-entry egress

---
 rtl/cam_learn_ctrl_pkg.sv | 28 ++
 rtl/cam_learn_ctrl_free_slot.sv | 38 +++
 rtl/cam_learn_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_cam_learn_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_learn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_learn_ctrl_pkg
// Description : Shared encodings for the MAC-table CAM sequencer.
//               State codes for the controller FSM and the operation type
//               that is latched when a request is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_learn_ctrl_pkg;

    // Controller state encoding
    localparam int              c_ST_W       = 3;
    localparam logic [c_ST_W-1:0] c_ST_INIT    = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_IDLE    = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_CMP     = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_EVAL    = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_WRITE   = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_WR = 3'd5;
    localparam logic [c_ST_W-1:0] c_ST_FLUSH   = 3'd6;

    // Operation in flight
    localparam int              c_OP_W       = 2;
    localparam logic [c_OP_W-1:0] c_OP_LOOKUP  = 2'd0;
    localparam logic [c_OP_W-1:0] c_OP_LEARN   = 2'd1;
    localparam logic [c_OP_W-1:0] c_OP_FLUSH   = 2'd2;

endpackage : cam_learn_ctrl_pkg
`default_nettype wire

// File: rtl/cam_learn_ctrl_free_slot.sv
`default_nettype none
// ============================================================================
// Module      : cam_learn_ctrl_free_slot
// Description : First-free slot finder. LSB-priority encoder over the
//               inverted valid bitmap.
//   i_valid  in  2**ADDR_WIDTH  per-entry valid bitmap
//   o_found  out 1              at least one entry is free
//   o_slot   out ADDR_WIDTH     lowest free entry index (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module cam_learn_ctrl_free_slot #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [(1<<ADDR_WIDTH)-1:0] i_valid,
    output logic                       o_found,
    output logic [ADDR_WIDTH-1:0]      o_slot
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [c_DEPTH-1:0] w_free;

    assign w_free = ~i_valid;

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_slot  = '0;
        for (int i = c_DEPTH - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                o_found = 1'b1;
                o_slot  = i[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule : cam_learn_ctrl_free_slot
`default_nettype wire

// File: rtl/cam_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_learn_ctrl
// Description : Sequencer for the block-RAM CAM holding the L2 MAC table.
//               Arbitrates lookup and learn requests onto the CAM compare and
//               write ports, keeps the per-entry egress port table and valid
//               bitmap, allocates slots (first free, else round-robin victim)
//               and performs a full-table flush on request.
//   clk, rst                     clock, synchronous active-high reset
//   lookup_valid_i/ready_o/mac_i lookup request handshake and key
//   lookup_resp_valid/hit/port_o one-cycle lookup response
//   learn_valid_i/ready_o        learn request handshake
//   learn_mac_i, learn_port_i    source MAC and its ingress port
//   flush_req_i                  pulse: delete every valid entry
//   busy_o                       high whenever the controller is not idle
//   cam_write_*                  CAM write port, cam_write_busy_i back-pressure
//   cam_compare_data_o           CAM search key
//   cam_match_i/match_addr_i     CAM encoded search result
// Revision    : 1.0 - initial release
// ============================================================================
module cam_learn_ctrl
    import cam_learn_ctrl_pkg::*;
#(
    parameter int MAC_WIDTH  = 48,
    parameter int ADDR_WIDTH = 5,
    parameter int PORT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid_i,
    output logic                  lookup_ready_o,
    input  logic [MAC_WIDTH-1:0]  lookup_mac_i,
    output logic                  lookup_resp_valid_o,
    output logic                  lookup_resp_hit_o,
    output logic [PORT_WIDTH-1:0] lookup_resp_port_o,
    input  logic                  learn_valid_i,
    output logic                  learn_ready_o,
    input  logic [MAC_WIDTH-1:0]  learn_mac_i,
    input  logic [PORT_WIDTH-1:0] learn_port_i,
    input  logic                  flush_req_i,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] cam_write_addr_o,
    output logic [MAC_WIDTH-1:0]  cam_write_data_o,
    output logic                  cam_write_delete_o,
    output logic                  cam_write_enable_o,
    input  logic                  cam_write_busy_i,
    output logic [MAC_WIDTH-1:0]  cam_compare_data_o,
    input  logic                  cam_match_i,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr_i
);

    localparam int                  c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = '1;

    // ------------------------------------------------------------------------
    // State and tables
    // ------------------------------------------------------------------------
    logic [c_ST_W-1:0]     r_state;
    logic [c_OP_W-1:0]     r_op;
    logic [MAC_WIDTH-1:0]  r_key;
    logic [PORT_WIDTH-1:0] r_port;
    logic [ADDR_WIDTH-1:0] r_slot;
    logic [ADDR_WIDTH-1:0] r_victim;
    logic [ADDR_WIDTH-1:0] r_flush_addr;
    logic                  r_flush_pend;
    logic                  r_rr_learn;     // 1: learn wins the next tie
    logic                  r_wait_skip;
    logic [c_DEPTH-1:0]    r_valid;
    logic [PORT_WIDTH-1:0] r_port_tbl [c_DEPTH];

    // Registered outputs
    logic                  r_busy;
    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic [PORT_WIDTH-1:0] r_resp_port;
    logic                  r_wr_en;
    logic                  r_wr_del;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [MAC_WIDTH-1:0]  r_wr_data;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic                  w_idle;
    logic                  w_flush_pend;
    logic                  w_grant_lookup;
    logic                  w_grant_learn;
    logic                  w_any_free;
    logic [ADDR_WIDTH-1:0] w_free_slot;

    assign w_idle       = (r_state == c_ST_IDLE);
    // A flush request arriving in the IDLE cycle itself already blocks grants.
    assign w_flush_pend = r_flush_pend | flush_req_i;

    assign w_grant_lookup = w_idle & ~w_flush_pend & lookup_valid_i &
                            (~learn_valid_i | ~r_rr_learn);
    assign w_grant_learn  = w_idle & ~w_flush_pend & learn_valid_i &
                            (~lookup_valid_i | r_rr_learn);

    assign lookup_ready_o = w_grant_lookup;
    assign learn_ready_o  = w_grant_learn;

    cam_learn_ctrl_free_slot #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_slot (
        .i_valid (r_valid),
        .o_found (w_any_free),
        .o_slot  (w_free_slot)
    );

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_INIT;
            r_op         <= c_OP_LOOKUP;
            r_key        <= '0;
            r_port       <= '0;
            r_slot       <= '0;
            r_victim     <= '0;
            r_flush_addr <= '0;
            r_flush_pend <= 1'b0;
            r_rr_learn   <= 1'b0;
            r_wait_skip  <= 1'b0;
            r_valid      <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_port_tbl[i] <= '0;
            end
            r_busy       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_port  <= '0;
            r_wr_en      <= 1'b0;
            r_wr_del     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_del     <= 1'b0;
            if (flush_req_i) begin
                r_flush_pend <= 1'b1;
            end

            case (r_state)
                c_ST_INIT: begin
                    // The CAM clears itself after reset; wait it out.
                    if (!cam_write_busy_i) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                c_ST_IDLE: begin
                    if (w_flush_pend) begin
                        r_op         <= c_OP_FLUSH;
                        r_flush_addr <= '0;
                        r_state      <= c_ST_FLUSH;
                        r_busy       <= 1'b1;
                    end else if (w_grant_lookup) begin
                        r_op       <= c_OP_LOOKUP;
                        r_key      <= lookup_mac_i;
                        r_rr_learn <= 1'b1;
                        r_state    <= c_ST_CMP;
                        r_busy     <= 1'b1;
                    end else if (w_grant_learn) begin
                        r_op       <= c_OP_LEARN;
                        r_key      <= learn_mac_i;
                        r_port     <= learn_port_i;
                        r_rr_learn <= 1'b0;
                        r_state    <= c_ST_CMP;
                        r_busy     <= 1'b1;
                    end
                end

                c_ST_CMP: begin
                    // Key is on the compare bus this cycle; result next cycle.
                    r_state <= c_ST_EVAL;
                end

                c_ST_EVAL: begin
                    if (r_op == c_OP_LOOKUP) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= cam_match_i;
                        r_resp_port  <= cam_match_i ? r_port_tbl[cam_match_addr_i] : '0;
                        r_state      <= c_ST_IDLE;
                        r_busy       <= 1'b0;
                    end else if (cam_match_i) begin
                        // Known station: only a port move needs recording.
                        if (r_port_tbl[cam_match_addr_i] != r_port) begin
                            r_port_tbl[cam_match_addr_i] <= r_port;
                        end
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_any_free) begin
                            r_slot <= w_free_slot;
                        end else begin
                            r_slot   <= r_victim;
                            r_victim <= r_victim + ADDR_WIDTH'(1);
                        end
                        r_state <= c_ST_WRITE;
                    end
                end

                c_ST_WRITE: begin
                    if (!cam_write_busy_i) begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= r_slot;
                        r_wait_skip <= 1'b1;
                        if (r_op == c_OP_FLUSH) begin
                            r_wr_del        <= 1'b1;
                            r_wr_data       <= '0;
                            r_valid[r_slot] <= 1'b0;
                        end else begin
                            // A victim overwrite needs no delete: the CAM
                            // drops the old key at this address itself.
                            r_wr_del           <= 1'b0;
                            r_wr_data          <= r_key;
                            r_valid[r_slot]    <= 1'b1;
                            r_port_tbl[r_slot] <= r_port;
                        end
                        r_state <= c_ST_WAIT_WR;
                    end
                end

                c_ST_WAIT_WR: begin
                    // First cycle: the CAM is only now sampling the write, so
                    // its busy flag is not meaningful yet.
                    if (r_wait_skip) begin
                        r_wait_skip <= 1'b0;
                    end else if (!cam_write_busy_i) begin
                        if (r_op == c_OP_FLUSH) begin
                            if (r_flush_addr == c_LAST) begin
                                r_flush_pend <= flush_req_i;
                                r_victim     <= '0;
                                r_state      <= c_ST_IDLE;
                                r_busy       <= 1'b0;
                            end else begin
                                r_flush_addr <= r_flush_addr + ADDR_WIDTH'(1);
                                r_state      <= c_ST_FLUSH;
                            end
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                c_ST_FLUSH: begin
                    if (r_valid[r_flush_addr]) begin
                        r_slot  <= r_flush_addr;
                        r_state <= c_ST_WRITE;
                    end else if (r_flush_addr == c_LAST) begin
                        // A new request during the walk survives the clear.
                        r_flush_pend <= flush_req_i;
                        r_victim     <= '0;
                        r_state      <= c_ST_IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_flush_addr <= r_flush_addr + ADDR_WIDTH'(1);
                    end
                end

                default: begin
                    r_state <= c_ST_INIT;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy_o              = r_busy;
    assign lookup_resp_valid_o = r_resp_valid;
    assign lookup_resp_hit_o   = r_resp_hit;
    assign lookup_resp_port_o  = r_resp_port;
    assign cam_write_enable_o  = r_wr_en;
    assign cam_write_delete_o  = r_wr_del;
    assign cam_write_addr_o    = r_wr_addr;
    assign cam_write_data_o    = r_wr_data;
    assign cam_compare_data_o  = r_key;

endmodule : cam_learn_ctrl
`default_nettype wire

// File: tb/tb_cam_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_learn_ctrl
// Description : Directed self-checking bench for cam_learn_ctrl with an
//               8-entry behavioural CAM attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_learn_ctrl;

    localparam int MW    = 48;
    localparam int AW    = 3;
    localparam int PW    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_valid;
    logic          lookup_ready;
    logic [MW-1:0] lookup_mac;
    logic          resp_valid;
    logic          resp_hit;
    logic [PW-1:0] resp_port;
    logic          learn_valid;
    logic          learn_ready;
    logic [MW-1:0] learn_mac;
    logic [PW-1:0] learn_port;
    logic          flush_req;
    logic          busy;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_data;
    logic          wr_del;
    logic          wr_en;
    logic          cam_busy;
    logic [MW-1:0] cmp_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;

    always #5 clk = ~clk;

    cam_learn_ctrl #(
        .MAC_WIDTH  (MW),
        .ADDR_WIDTH (AW),
        .PORT_WIDTH (PW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .lookup_valid_i      (lookup_valid),
        .lookup_ready_o      (lookup_ready),
        .lookup_mac_i        (lookup_mac),
        .lookup_resp_valid_o (resp_valid),
        .lookup_resp_hit_o   (resp_hit),
        .lookup_resp_port_o  (resp_port),
        .learn_valid_i       (learn_valid),
        .learn_ready_o       (learn_ready),
        .learn_mac_i         (learn_mac),
        .learn_port_i        (learn_port),
        .flush_req_i         (flush_req),
        .busy_o              (busy),
        .cam_write_addr_o    (wr_addr),
        .cam_write_data_o    (wr_data),
        .cam_write_delete_o  (wr_del),
        .cam_write_enable_o  (wr_en),
        .cam_write_busy_i    (cam_busy),
        .cam_compare_data_o  (cmp_data),
        .cam_match_i         (cam_match),
        .cam_match_addr_i    (cam_match_addr)
    );

    // ------------------------------------------------------------------------
    // Behavioural CAM: registered search (1 cycle), 2-cycle write busy,
    // 4-cycle self-clear after reset. Also logs write traffic.
    // ------------------------------------------------------------------------
    logic [MW-1:0]    cam_k [DEPTH];
    logic [DEPTH-1:0] cam_v;
    int               cam_cnt;
    int               wr_cnt       = 0;
    int               del_cnt      = 0;
    int               learn_wr_cnt = 0;
    int               learn_seq    = 0;
    int               en_busy_cnt  = 0;
    logic [AW-1:0]    last_wr_addr = '0;
    logic             last_wr_del  = 1'b0;
    logic [AW-1:0]    last_learn_addr = '0;

    always @(posedge clk) begin
        cam_match      <= 1'b0;
        cam_match_addr <= '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cam_v[i] && cam_k[i] == cmp_data) begin
                cam_match      <= 1'b1;
                cam_match_addr <= i[AW-1:0];
            end
        end
        if (rst) begin
            cam_v    <= '0;
            cam_busy <= 1'b1;
            cam_cnt  <= 4;
        end else begin
            if (wr_en && cam_busy) en_busy_cnt <= en_busy_cnt + 1;
            if (cam_cnt != 0) begin
                cam_cnt <= cam_cnt - 1;
                if (cam_cnt == 1) cam_busy <= 1'b0;
            end else if (wr_en) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= wr_addr;
                last_wr_del  <= wr_del;
                if (wr_del) begin
                    cam_v[wr_addr] <= 1'b0;
                    del_cnt        <= del_cnt + 1;
                end else begin
                    cam_v[wr_addr]  <= 1'b1;
                    cam_k[wr_addr]  <= wr_data;
                    learn_wr_cnt    <= learn_wr_cnt + 1;
                    learn_seq       <= wr_cnt;
                    last_learn_addr <= wr_addr;
                end
                cam_busy <= 1'b1;
                cam_cnt  <= 2;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] mac_n(input int i);
        return 48'h0200_0000_1000 + MW'(i);
    endfunction

    task automatic do_lookup(input logic [MW-1:0] mac, output logic hit,
                             output logic [PW-1:0] port, output int lat);
        int n;
        @(negedge clk);
        lookup_mac   = mac;
        lookup_valid = 1'b1;
        #1;
        n = 0;
        while (!lookup_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 300) check("lookup_grant_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        lat  = 0;
        hit  = 1'b0;
        port = '0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                hit  = resp_hit;
                port = resp_port;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) check(tag, 64'(n), 64'd0);
    endtask

    task automatic do_learn(input logic [MW-1:0] mac, input logic [PW-1:0] port);
        int n;
        @(negedge clk);
        learn_mac   = mac;
        learn_port  = port;
        learn_valid = 1'b1;
        #1;
        n = 0;
        while (!learn_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 300) check("learn_grant_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        learn_valid = 1'b0;
        wait_idle("learn_idle_timeout");
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic          lk_hit;
    logic [PW-1:0] lk_port;
    int            lk_lat;
    int            w0;
    int            d0;
    int            l0;
    logic          seen;
    logic [3:0]    grants;

    initial begin
        rst          = 1'b1;
        lookup_valid = 1'b0;
        lookup_mac   = '0;
        learn_valid  = 1'b0;
        learn_mac    = '0;
        learn_port   = '0;
        flush_req    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",       64'(busy), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_wr_en",      64'(wr_en), 64'd0);
        check("rst_cmp_data",   64'(cmp_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("init_busy", 64'(busy), 64'd1);

        // Lookup on an empty table, issued while CAM still self-clearing
        do_lookup(48'h0011_2233_4455, lk_hit, lk_port, lk_lat);
        check("empty_hit",  64'(lk_hit), 64'd0);
        check("empty_port", 64'(lk_port), 64'd0);
        check("empty_lat",  64'(lk_lat), 64'd3);

        // First learn lands in slot 0
        w0 = wr_cnt;
        do_learn(48'hAAAA_AAAA_AA01, 2'd2);
        check("learn1_writes", 64'(wr_cnt - w0), 64'd1);
        check("learn1_addr",   64'(last_wr_addr), 64'd0);
        check("learn1_del",    64'(last_wr_del), 64'd0);
        do_lookup(48'hAAAA_AAAA_AA01, lk_hit, lk_port, lk_lat);
        check("lk1_hit",  64'(lk_hit), 64'd1);
        check("lk1_port", 64'(lk_port), 64'd2);
        check("lk1_lat",  64'(lk_lat), 64'd3);

        // Station move: port table only, no CAM write
        w0 = wr_cnt;
        do_learn(48'hAAAA_AAAA_AA01, 2'd3);
        check("move_writes", 64'(wr_cnt - w0), 64'd0);
        do_lookup(48'hAAAA_AAAA_AA01, lk_hit, lk_port, lk_lat);
        check("move_hit",  64'(lk_hit), 64'd1);
        check("move_port", 64'(lk_port), 64'd3);

        // Reset in the middle of a lookup: no response, table empty after
        @(negedge clk);
        lookup_mac   = 48'hAAAA_AAAA_AA01;
        lookup_valid = 1'b1;
        #1;
        check("midrst_ready", 64'(lookup_ready), 64'd1);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            seen = seen | resp_valid;
        end
        check("midrst_noresp", 64'(seen), 64'd0);
        do_lookup(48'hAAAA_AAAA_AA01, lk_hit, lk_port, lk_lat);
        check("midrst_lk_hit", 64'(lk_hit), 64'd0);

        // Fill all 8 slots, then the 9th evicts slot 0, 10th evicts slot 1
        for (int i = 0; i < 10; i++) begin
            w0 = wr_cnt;
            do_learn(mac_n(i), PW'((i + 1) % 4));
            check($sformatf("fill%0d_writes", i), 64'(wr_cnt - w0), 64'd1);
            check($sformatf("fill%0d_addr", i), 64'(last_wr_addr),
                  (i < 8) ? 64'(i) : 64'(i - 8));
        end
        do_lookup(mac_n(0), lk_hit, lk_port, lk_lat);
        check("victim_m0_hit", 64'(lk_hit), 64'd0);
        do_lookup(mac_n(1), lk_hit, lk_port, lk_lat);
        check("victim_m1_hit", 64'(lk_hit), 64'd0);
        do_lookup(mac_n(8), lk_hit, lk_port, lk_lat);
        check("victim_m8_hit",  64'(lk_hit), 64'd1);
        check("victim_m8_port", 64'(lk_port), 64'd1);
        do_lookup(mac_n(7), lk_hit, lk_port, lk_lat);
        check("victim_m7_hit",  64'(lk_hit), 64'd1);
        check("victim_m7_port", 64'(lk_port), 64'd0);

        // Leave a learn as the last grant, then hold both requesters
        do_learn(mac_n(7), 2'd0);
        w0 = wr_cnt;
        @(negedge clk);
        lookup_mac   = mac_n(8);
        learn_mac    = mac_n(7);
        learn_port   = 2'd0;
        lookup_valid = 1'b1;
        learn_valid  = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            int n;
            n = 0;
            while (!(lookup_ready || learn_ready) && n < 100) begin
                @(negedge clk); #1; n++;
            end
            if (n >= 100) check("alt_grant_timeout", 64'(n), 64'd0);
            check($sformatf("alt%0d_both", g), 64'(lookup_ready & learn_ready), 64'd0);
            grants[g] = lookup_ready;
            @(posedge clk); #1;
            if (g == 3) begin
                lookup_valid = 1'b0;
                learn_valid  = 1'b0;
            end
        end
        wait_idle("alt_idle_timeout");
        check("alt_grants", 64'(grants), 64'b0101);
        check("alt_writes", 64'(wr_cnt - w0), 64'd0);

        // Flush requested while a learn is in flight (table full, victim 2)
        w0 = wr_cnt;
        d0 = del_cnt;
        l0 = learn_wr_cnt;
        @(negedge clk);
        learn_mac   = mac_n(10);
        learn_port  = 2'd3;
        learn_valid = 1'b1;
        #1;
        check("fl_learn_ready", 64'(learn_ready), 64'd1);
        @(posedge clk); #1;
        learn_valid = 1'b0;
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        begin
            int n;
            n = 0;
            while (!((del_cnt - d0) == 8 && !busy) && n < 600) begin
                @(negedge clk); n++;
            end
            if (n >= 600) check("flush_timeout", 64'(n), 64'd0);
        end
        check("fl_learn_writes", 64'(learn_wr_cnt - l0), 64'd1);
        check("fl_learn_first",  64'(learn_seq), 64'(w0));
        check("fl_learn_addr",   64'(last_learn_addr), 64'd2);
        check("fl_deletes",      64'(del_cnt - d0), 64'd8);
        check("fl_last_addr",    64'(last_wr_addr), 64'd7);
        check("fl_last_del",     64'(last_wr_del), 64'd1);
        do_lookup(mac_n(10), lk_hit, lk_port, lk_lat);
        check("fl_m10_hit", 64'(lk_hit), 64'd0);
        do_lookup(mac_n(8), lk_hit, lk_port, lk_lat);
        check("fl_m8_hit", 64'(lk_hit), 64'd0);
        do_lookup(mac_n(3), lk_hit, lk_port, lk_lat);
        check("fl_m3_hit",  64'(lk_hit), 64'd0);
        check("fl_m3_port", 64'(lk_port), 64'd0);

        // Table restarts from slot 0 after the flush
        do_learn(mac_n(11), 2'd1);
        check("post_fl_addr", 64'(last_wr_addr), 64'd0);
        do_lookup(mac_n(11), lk_hit, lk_port, lk_lat);
        check("post_fl_hit",  64'(lk_hit), 64'd1);
        check("post_fl_port", 64'(lk_port), 64'd1);

        check("en_while_busy", 64'(en_busy_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cam_learn_ctrl
`default_nettype wire
